burst_memory: RTL and testbench
===============================

BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h80020000, lowest valid byte address.
REQ-002 SHALL have parameter DEPTH_BYTES, default 1048576, number of bytes stored; multiple of 4.
REQ-003 SHALL have parameter READ_LATENCY, default 1, acceptance-to-first-read-beat cycles; legal range 1..8.
REQ-004 SHALL have port clk, input, 1 bit; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit; request present.
REQ-007 SHALL have port req_ready, output, 1 bit; block accepts a request this cycle.
REQ-008 SHALL have port address, input, 32 bits; byte address of first beat.
REQ-009 SHALL have port data_in, input, 32 bits; write data, right-justified for sub-word writes.
REQ-010 SHALL have port write, input, 1 bit; 1 = write, 0 = read.
REQ-011 SHALL have port access_size, input, 2 bits; 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-012 SHALL have port burst_len, input, 2 bits; read beats minus 1 (1..4); ignored for writes.
REQ-013 SHALL have port rsp_valid, output, 1 bit; one response beat this cycle.
REQ-014 SHALL have port data_out, output, 32 bits; read data, zero-extended sub-word in low bits.
REQ-015 SHALL have port rsp_error, output, 1 bit; qualifies current beat as failed.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
REQ-017 SHALL store bytes big-endian: word at A holds byte A in bits 31:24, byte A+3 in bits 7:0.
REQ-018 SHALL flag a beat as error when its address is < BASE_ADDR, when address+size > BASE_ADDR+DEPTH_BYTES, when halfword address is odd, when word address is not a multiple of 4, or when access_size = 11.
REQ-019 SHALL implement states IDLE and READ; req_ready = 1 only in IDLE with reset low.
REQ-020 SHALL, on an accepted non-error write, update the addressed bytes at the acceptance edge, remain in IDLE, and pulse rsp_valid for the next cycle with data_out = 0 and rsp_error = 0.
REQ-021 SHALL, on an accepted error write, leave memory unchanged and pulse rsp_valid the next cycle with rsp_error = 1 and data_out = 0.
REQ-022 SHALL support back-to-back writes at one per cycle.
REQ-023 SHALL, on an accepted read, enter READ, latch address, access_size and burst_len, and assert rsp_valid for the first beat exactly READ_LATENCY cycles after the acceptance edge.
REQ-024 SHALL deliver remaining beats on consecutive cycles, each beat address = previous + (1, 2 or 4 bytes per access_size).
REQ-025 SHALL check each beat independently; an error beat drives data_out = 0, rsp_error = 1; bursts never wrap past the top of memory.
REQ-026 SHALL return to IDLE on the edge that launches the last beat, so req_ready is 1 during the last beat's rsp_valid cycle.
REQ-027 SHALL return read data reflecting all writes accepted before the read's acceptance edge.
REQ-028 SHALL hold data_out = 0 and rsp_error = 0 whenever rsp_valid = 0.

Reset
REQ-029 SHALL, on any edge with reset = 1, force state IDLE, rsp_valid = 0, rsp_error = 0, data_out = 0, and clear the latency and beat counters.
REQ-030 SHALL drive req_ready = 0 while reset = 1; requests presented then are not accepted.
REQ-031 SHALL abort an in-progress burst on reset with no further beats issued; memory contents are not cleared by reset.

Verification
REQ-032 Word write 0x98765432 at 0x80020000, then reads at 0x80020000 -> word 0x98765432, halfword 0x00009876, byte 0x00000098, each one READ_LATENCY after acceptance.
REQ-033 Halfword write 0xAAAA at 0x80020008 and byte write 0xBB at 0x8002000D back-to-back -> word read at 0x80020008 = 0xAAAA0000, word read at 0x8002000C = 0x00BB0000.
REQ-034 Words 0x11111111..0x44444444 at 0x80020010..0x8002001C; read burst_len=3, READ_LATENCY=3 -> rsp_valid on cycles 3,4,5,6 after acceptance with the four values in order; req_ready 0 through cycle 5, 1 on cycle 6.
REQ-035 Word read at 0x80020002, halfword write at 0x80020001, access_size 11, read at 0x8001FFFC -> single rsp_valid with rsp_error = 1, data_out = 0; memory unchanged.
REQ-036 Word burst_len=3 at BASE_ADDR+DEPTH_BYTES-8 -> beats 0,1 valid data, beats 2,3 rsp_error = 1.
REQ-037 Reset asserted after second beat of a 4-beat burst -> no further rsp_valid; previously written data still readable afterwards.

Source files
------------

// File: rtl/burst_memory.sv
// Big-endian byte/halfword/word memory with read bursts of 1..4 beats; first read beat READ_LATENCY cycles after accept, write ack next cycle.
// Backpressure: req_ready is high only while idle and out of reset, so a burst blocks new requests until its last beat.
module burst_memory #(
  parameter logic [31:0] BASE_ADDR    = 32'h80020000,
  parameter int          DEPTH_BYTES  = 1048576,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        write,
  input  logic [1:0]  access_size,
  input  logic [1:0]  burst_len,
  output logic        rsp_valid,
  output logic [31:0] data_out,
  output logic        rsp_error
);

  localparam int          WORDS    = DEPTH_BYTES / 4;
  localparam int          IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int          LAT_INIT = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;
  localparam logic [33:0] LIMIT    = {2'b00, BASE_ADDR} + 34'(DEPTH_BYTES);

  typedef enum logic {IDLE, READ} state_t;

  state_t      r_state;
  logic [32:0] r_addr;
  logic [1:0]  r_size;
  logic [1:0]  r_beats;
  logic [2:0]  r_lat;
  logic        r_rsp_valid;
  logic        r_rsp_error;
  logic [31:0] r_data_out;
  logic [31:0] r_mem [WORDS];

  logic        w_accept;
  logic [32:0] w_beat_addr;
  logic [1:0]  w_beat_size;
  logic [32:0] w_offset;
  logic [1:0]  w_off;
  logic [IW-1:0] w_idx;
  logic [33:0] w_end;
  logic        w_err;
  logic [31:0] w_word;
  logic [31:0] w_rdata;
  logic [31:0] w_wdata;
  logic [3:0]  w_wbe;
  logic [32:0] w_next_addr;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_error = r_rsp_error;
  assign data_out  = r_data_out;

  // While idle the beat under test is the incoming request, otherwise the latched burst pointer.
  assign w_beat_addr = (r_state == IDLE) ? {1'b0, address} : r_addr;
  assign w_beat_size = (r_state == IDLE) ? access_size : r_size;
  assign w_offset    = w_beat_addr - {1'b0, BASE_ADDR};
  assign w_off       = w_offset[1:0];
  assign w_idx       = IW'(w_offset >> 2);
  assign w_word      = r_mem[w_idx];
  assign w_end       = {1'b0, w_beat_addr} + 34'(size_bytes(w_beat_size));
  assign w_next_addr = w_beat_addr + 33'(size_bytes(w_beat_size));

  always_comb begin
    w_err = 1'b0;
    if (w_beat_size == 2'b11)                        w_err = 1'b1;
    if (w_beat_addr < {1'b0, BASE_ADDR})             w_err = 1'b1;
    if (w_end > LIMIT)                               w_err = 1'b1;
    if (w_beat_size == 2'b01 && w_beat_addr[0])      w_err = 1'b1;
    if (w_beat_size == 2'b10 && w_beat_addr[1:0] != 2'b00) w_err = 1'b1;
  end

  // Byte offset 0 lives in bits 31:24, so lane index is the inverted offset.
  always_comb begin
    w_rdata = w_word;
    w_wdata = data_in;
    w_wbe   = 4'b1111;
    case (w_beat_size)
      2'b00: begin
        w_rdata = {24'h0, w_word[{~w_off, 3'b000} +: 8]};
        w_wdata = {4{data_in[7:0]}};
        w_wbe   = 4'b0001 << ~w_off;
      end
      2'b01: begin
        w_rdata = w_off[1] ? {16'h0, w_word[15:0]} : {16'h0, w_word[31:16]};
        w_wdata = {2{data_in[15:0]}};
        w_wbe   = w_off[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        w_rdata = w_word;
        w_wdata = data_in;
        w_wbe   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept && write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wbe[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_size      <= '0;
      r_beats     <= '0;
      r_lat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_data_out  <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (write) begin
              r_rsp_valid <= 1'b1;
              r_rsp_error <= w_err;
            end else begin
              r_size <= access_size;
              if (READ_LATENCY <= 1) begin
                r_rsp_valid <= 1'b1;
                r_rsp_error <= w_err;
                r_data_out  <= w_err ? 32'h0 : w_rdata;
                r_addr      <= w_next_addr;
                r_beats     <= burst_len - 2'd1;
                r_lat       <= '0;
                r_state     <= (burst_len == 2'd0) ? IDLE : READ;
              end else begin
                r_addr  <= {1'b0, address};
                r_beats <= burst_len;
                r_lat   <= 3'(LAT_INIT);
                r_state <= READ;
              end
            end
          end
        end
        READ: begin
          if (r_lat != 3'd0) begin
            r_lat <= r_lat - 3'd1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_error <= w_err;
            r_data_out  <= w_err ? 32'h0 : w_rdata;
            if (r_beats == 2'd0) begin
              r_state <= IDLE;
            end else begin
              r_beats <= r_beats - 2'd1;
              r_addr  <= w_next_addr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_memory.sv
// Scoreboard bench for burst_memory: a byte-level model predicts every response beat and its cycle.
module tb_burst_memory;

  localparam logic [31:0]     BASE  = 32'h80020000;
  localparam int              DEPTH = 4096;
  localparam int              RL    = 3;
  localparam longint unsigned TOP   = 64'h80020000 + 64'd4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        write;
  logic [1:0]  access_size;
  logic [1:0]  burst_len;
  logic        rsp_valid;
  logic [31:0] data_out;
  logic        rsp_error;

  burst_memory #(.BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .data_in(data_in), .write(write), .access_size(access_size),
    .burst_len(burst_len), .rsp_valid(rsp_valid), .data_out(data_out), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        obs_q[$];
  logic        rdy_log[int];
  logic [7:0]  mmem[int unsigned];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          idle_bad = 0;
  bit          started = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (started) begin
      rdy_log[cyc] = req_ready;
      if (rsp_valid === 1'b1) obs_q.push_back('{data_out, rsp_error, cyc});
      else if (data_out !== 32'h0 || rsp_error !== 1'b0) idle_bad++;
    end
  end

  function automatic logic [7:0] rd8(input longint unsigned a);
    int unsigned k = int'(a[31:0]);
    return mmem.exists(k) ? mmem[k] : 8'h00;
  endfunction

  function automatic longint unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_err(input longint unsigned a, input logic [1:0] sz);
    return (sz == 2'b11) || (a < 64'(BASE)) || (a + nbytes(sz) > TOP) ||
           (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_read(input longint unsigned a, input logic [1:0] sz);
    case (sz)
      2'b00:   return {24'h0, rd8(a)};
      2'b01:   return {16'h0, rd8(a), rd8(a + 1)};
      default: return {rd8(a), rd8(a + 1), rd8(a + 2), rd8(a + 3)};
    endcase
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00: mmem[a] = d[7:0];
      2'b01: begin mmem[a] = d[15:8]; mmem[a + 1] = d[7:0]; end
      default: begin
        mmem[a] = d[31:24]; mmem[a + 1] = d[23:16];
        mmem[a + 2] = d[15:8]; mmem[a + 3] = d[7:0];
      end
    endcase
  endtask

  // Drives one request, returns the cycle index of its acceptance edge and queues its expected beats.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic [1:0] bl, output int acc);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; write = w; address = a; data_in = d; access_size = sz; burst_len = bl;
    while (req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, want 1", req_ready, t);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    if (w) begin
      exp_q.push_back('{32'h0, m_err(64'(a), sz), acc});
      if (!m_err(64'(a), sz)) m_write(a, d, sz);
    end else begin
      for (int b = 0; b <= int'(bl); b++) begin
        longint unsigned ba = 64'(a) + longint'(b) * nbytes(sz);
        bit e = m_err(ba, sz);
        exp_q.push_back('{e ? 32'h0 : m_read(ba, sz), e, acc + RL - 1 + b});
      end
    end
  endtask

  task automatic settle(output bit ok);
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 100) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    ok = (obs_q.size() >= exp_q.size());
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; write = 1'b1; address = BASE; data_in = 32'hDEADDEAD;
    access_size = 2'b10; burst_len = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", data_out); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", rsp_error); end
    reset = 1'b0; req_valid = 1'b0;
    started = 1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_no_accept: rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_word_rw;
    int acc; bit ok; rsp_t e, o;
    issue(1'b1, 32'h80020000, 32'h98765432, 2'b10, 2'b00, acc);
    issue(1'b0, 32'h80020000, 32'h0, 2'b10, 2'b00, acc);
    issue(1'b0, 32'h80020000, 32'h0, 2'b01, 2'b00, acc);
    issue(1'b0, 32'h80020000, 32'h0, 2'b00, 2'b00, acc);
    settle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL word_rw_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.data !== e.data || o.err !== e.err || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL word_rw beat: got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d", o.data, o.err, o.cyc, e.data, e.err, e.cyc);
      end
    end
    checks++; if (obs_q.size() != 0 || exp_q.size() != 0) begin failures++; $display("FAIL word_rw_count: got %0d extra want %0d extra", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int acc; bit ok; rsp_t e, o; logic [31:0] got[$];
    issue(1'b1, 32'h80020008, 32'h0000AAAA, 2'b01, 2'b00, acc);
    issue(1'b1, 32'h8002000D, 32'h000000BB, 2'b00, 2'b00, acc);
    issue(1'b0, 32'h80020008, 32'h0, 2'b10, 2'b00, acc);
    issue(1'b0, 32'h8002000C, 32'h0, 2'b10, 2'b00, acc);
    settle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; got.push_back(o.data);
      if (o.data !== e.data || o.err !== e.err || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL b2b beat: got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d", o.data, o.err, o.cyc, e.data, e.err, e.cyc);
      end
    end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL b2b_count: got %0d beats want 4", got.size()); end
    else begin
      checks++; if (got[2] !== 32'hAAAA0000) begin failures++; $display("FAIL b2b_word8: got %h want aaaa0000", got[2]); end
      checks++; if (got[3] !== 32'h00BB0000) begin failures++; $display("FAIL b2b_wordc: got %h want 00bb0000", got[3]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_burst;
    int acc; bit ok; rsp_t e, o;
    issue(1'b1, 32'h80020010, 32'h11111111, 2'b10, 2'b00, acc);
    issue(1'b1, 32'h80020014, 32'h22222222, 2'b10, 2'b00, acc);
    issue(1'b1, 32'h80020018, 32'h33333333, 2'b10, 2'b00, acc);
    issue(1'b1, 32'h8002001C, 32'h44444444, 2'b10, 2'b00, acc);
    issue(1'b0, 32'h80020010, 32'h0, 2'b10, 2'b11, acc);
    settle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.data !== e.data || o.err !== e.err || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL burst beat: got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d", o.data, o.err, o.cyc, e.data, e.err, e.cyc);
      end
    end
    checks++; if (obs_q.size() != 0 || exp_q.size() != 0) begin failures++; $display("FAIL burst_count: got %0d extra want %0d extra", obs_q.size(), exp_q.size()); end
    for (int k = 0; k <= 5; k++) begin
      logic want = (k == 5);
      checks++;
      if (!rdy_log.exists(acc + k) || rdy_log[acc + k] !== want) begin
        failures++;
        $display("FAIL burst_ready cycle %0d: got %b want %b", k + 1, rdy_log.exists(acc + k) ? rdy_log[acc + k] : 1'bx, want);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors;
    int acc; bit ok; rsp_t e, o;
    issue(1'b0, 32'h80020002, 32'h0, 2'b10, 2'b00, acc);
    issue(1'b1, 32'h80020001, 32'h00001234, 2'b01, 2'b00, acc);
    issue(1'b0, 32'h80020000, 32'h0, 2'b11, 2'b00, acc);
    issue(1'b1, 32'h80020000, 32'h5555AAAA, 2'b11, 2'b00, acc);
    issue(1'b0, 32'h8001FFFC, 32'h0, 2'b10, 2'b00, acc);
    issue(1'b0, 32'h80020000, 32'h0, 2'b10, 2'b00, acc);
    settle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL err_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.data !== e.data || o.err !== e.err || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL err beat: got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d", o.data, o.err, o.cyc, e.data, e.err, e.cyc);
      end
    end
    checks++; if (obs_q.size() != 0 || exp_q.size() != 0) begin failures++; $display("FAIL err_count: got %0d extra want %0d extra", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_top_boundary;
    int acc; bit ok; rsp_t e, o;
    issue(1'b1, 32'h80020FF8, 32'hCAFEF00D, 2'b10, 2'b00, acc);
    issue(1'b1, 32'h80020FFC, 32'h0BADBEEF, 2'b10, 2'b00, acc);
    issue(1'b1, 32'h80021000, 32'h12345678, 2'b10, 2'b00, acc);
    issue(1'b0, 32'h80020FF8, 32'h0, 2'b10, 2'b11, acc);
    issue(1'b0, 32'h80020FFE, 32'h0, 2'b00, 2'b11, acc);
    issue(1'b0, 32'h80020FFE, 32'h0, 2'b01, 2'b01, acc);
    settle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL top_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.data !== e.data || o.err !== e.err || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL top beat: got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d", o.data, o.err, o.cyc, e.data, e.err, e.cyc);
      end
    end
    checks++; if (obs_q.size() != 0 || exp_q.size() != 0) begin failures++; $display("FAIL top_count: got %0d extra want %0d extra", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_abort;
    int acc; bit ok; rsp_t e, o;
    issue(1'b0, 32'h80020010, 32'h0, 2'b10, 2'b11, acc);
    do @(negedge clk); while (cyc < acc + RL);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL abort_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b want 0", rsp_valid); end
    reset = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    settle(ok);
    issue(1'b0, 32'h80020010, 32'h0, 2'b10, 2'b01, acc);
    settle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.data !== e.data || o.err !== e.err || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL abort beat: got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d", o.data, o.err, o.cyc, e.data, e.err, e.cyc);
      end
    end
    checks++; if (obs_q.size() != 0 || exp_q.size() != 0) begin failures++; $display("FAIL abort_count: got %0d extra want %0d extra", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_idle_outputs;
    checks++;
    if (idle_bad != 0) begin failures++; $display("FAIL idle_outputs: got %0d nonzero idle cycles want 0", idle_bad); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; write = 1'b0; address = '0; data_in = '0;
    access_size = '0; burst_len = '0;
    test_reset;
    test_word_rw;
    test_back_to_back;
    test_burst;
    test_errors;
    test_top_boundary;
    test_reset_abort;
    test_idle_outputs;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
